// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg
//   Shared constants, FSM state encoding and a beat-count helper for the
//   data-memory arbiter that multiplexes a scalar port and a vector burst
//   port onto one single-port dsram.
package dmem_arbiter_pkg;

    localparam int MEM_AW = 8;           // dsram word-address width
    localparam int DW     = 32;          // data width
    localparam int VLEN_W = 4;           // burst length field width
    localparam int CNT_W  = VLEN_W + 1;  // one extra bit so a 0 length means 16 beats

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VBURST = 2'd1,
        ST_VDONE  = 2'd2
    } state_t;

    // Number of beats in a burst; the all-zero length encodes the maximum.
    function automatic logic [CNT_W-1:0] beat_total(input logic [VLEN_W-1:0] len);
        return (len == '0) ? CNT_W'(2 ** VLEN_W) : CNT_W'(len);
    endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Arbitrates a scalar load/store port and a vector burst port onto a
//   single-port dsram (registered read data, active-low write enable).
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     s_req/s_we/s_addr/s_wdata  scalar request; s_grant is combinational,
//     s_grant/s_stall            s_stall = s_req & ~s_grant
//     s_rvalid/s_rdata           scalar read return, one cycle after grant
//     v_req/v_we/v_base/v_len    burst request, held until v_done
//     v_wdata/v_wready           write-burst data and per-beat consume strobe
//     v_rvalid/v_rdata/v_ridx    read-burst return with beat index
//     v_done                     one-cycle end-of-burst pulse
//     mem_addr/mem_en_wr/        dsram interface
//     mem_wdata/mem_rdata
module dmem_arbiter
    import dmem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    // scalar port
    input  logic              s_req,
    input  logic              s_we,
    input  logic [MEM_AW-1:0] s_addr,
    input  logic [DW-1:0]     s_wdata,
    output logic              s_grant,
    output logic              s_stall,
    output logic              s_rvalid,
    output logic [DW-1:0]     s_rdata,
    // vector port
    input  logic              v_req,
    input  logic              v_we,
    input  logic [MEM_AW-1:0] v_base,
    input  logic [VLEN_W-1:0] v_len,
    input  logic [DW-1:0]     v_wdata,
    output logic              v_wready,
    output logic              v_rvalid,
    output logic [DW-1:0]     v_rdata,
    output logic [VLEN_W-1:0] v_ridx,
    output logic              v_done,
    // dsram port
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_en_wr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata
);

    state_t              state_q, state_d;
    logic                rr_vec_q;      // 1: vector wins the next tie
    logic [MEM_AW-1:0]   base_q;
    logic [CNT_W-1:0]    total_q;
    logic                we_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                s_rvalid_q;
    logic                v_rvalid_q;
    logic [VLEN_W-1:0]   v_ridx_q;

    logic                v_latch;       // burst accepted this cycle
    logic                beat;          // one burst beat issued this cycle

    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        s_grant   = 1'b0;
        v_latch   = 1'b0;
        beat      = 1'b0;
        v_wready  = 1'b0;
        v_done    = 1'b0;
        mem_addr  = '0;
        mem_en_wr = 1'b1;
        mem_wdata = '0;

        unique case (state_q)
            ST_IDLE: begin
                // Arbitration is held off while reset is asserted so no
                // grant or access can leak out during reset.
                if (rst_n) begin
                    if (s_req && (!v_req || !rr_vec_q)) begin
                        s_grant   = 1'b1;
                        mem_addr  = s_addr;
                        mem_en_wr = ~s_we;
                        mem_wdata = s_wdata;
                    end else if (v_req) begin
                        v_latch = 1'b1;
                        state_d = ST_VBURST;
                    end
                end
            end
            ST_VBURST: begin
                beat      = 1'b1;
                mem_addr  = base_q + MEM_AW'(cnt_q);  // wraps 255 -> 0
                mem_en_wr = ~we_q;
                v_wready  = we_q;
                mem_wdata = we_q ? v_wdata : '0;
                if (cnt_q == total_q - CNT_W'(1))
                    state_d = ST_VDONE;
            end
            ST_VDONE: begin
                v_done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rr_vec_q   <= 1'b0;
            base_q     <= '0;
            total_q    <= '0;
            we_q       <= 1'b0;
            cnt_q      <= '0;
            s_rvalid_q <= 1'b0;
            v_rvalid_q <= 1'b0;
            v_ridx_q   <= '0;
        end else begin
            state_q <= state_d;

            // The winner of any grant becomes the loser of the next tie.
            if (s_grant)
                rr_vec_q <= 1'b1;
            else if (v_latch)
                rr_vec_q <= 1'b0;

            if (v_latch) begin
                base_q  <= v_base;
                total_q <= beat_total(v_len);
                we_q    <= v_we;
                cnt_q   <= '0;
            end else if (beat) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            // Read data from the dsram arrives one cycle after the address.
            s_rvalid_q <= s_grant & ~s_we;
            v_rvalid_q <= beat & ~we_q;
            if (beat)
                v_ridx_q <= cnt_q[VLEN_W-1:0];
        end
    end

    assign s_stall  = s_req & ~s_grant;
    assign s_rvalid = s_rvalid_q;
    assign s_rdata  = mem_rdata;
    assign v_rvalid = v_rvalid_q;
    assign v_rdata  = mem_rdata;
    assign v_ridx   = v_ridx_q;

endmodule
